// File: rtl/seg7_mmio_display.sv
// seg7_mmio_display
// Memory-mapped 8-digit seven-segment display peripheral. It snoops the CPU
// write bus, keeps a 32-bit display register, and scans that register onto a
// common-anode display as eight hex digits, one digit slot every
// 2^SCAN_DIV clock cycles.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active low
//   we     - CPU write strobe
//   wsize  - access size: 00 word, 01 halfword, 10 byte, 11 reserved
//   addr   - CPU byte address (undecoded)
//   wdata  - write data; halfword in [15:0], byte in [7:0]
//   hit    - combinational address match on the display word
//   rdata  - combinational read-back of the display register
//   o_seg  - registered segments, active low, {dp,g,f,e,d,c,b,a}
//   o_sel  - registered digit enables, active low, one-hot, bit 0 = rightmost
//
// Build option:
//   SEG7_LEADING_ZERO_BLANK_EN - when defined, leading zero digits above
//   digit 0 are blanked instead of showing "0".
module seg7_mmio_display #(
    parameter logic [31:0] DISP_ADDR = 32'h1001_FFF0,
    parameter int          SCAN_DIV  = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  wsize,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic [7:0]  o_seg,
    output logic [7:0]  o_sel
);

    localparam int CNT_W = SCAN_DIV + 3;

    // Segment pattern {g,f,e,d,c,b,a}, active low.
    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    logic [31:0]      disp_q, disp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       seg_q, seg_d;
    logic [7:0]       sel_q, sel_d;
    logic [2:0]       idx_s;
    logic [3:0]       nibble_s;
    logic             blank_s;

    assign hit   = (addr[31:2] == DISP_ADDR[31:2]);
    assign rdata = disp_q;
    assign o_seg = seg_q;
    assign o_sel = sel_q;

    // Little-endian lane merge of accepted writes; misaligned or reserved sizes leave the register alone.
    always_comb begin
        disp_d = disp_q;
        if (we && hit) begin
            case (wsize)
                2'b00: begin
                    if (addr[1:0] == 2'b00) begin
                        disp_d = wdata;
                    end else begin
                        disp_d = disp_q;
                    end
                end
                2'b01: begin
                    if (addr[0] == 1'b0) begin
                        if (addr[1]) begin
                            disp_d[31:16] = wdata[15:0];
                        end else begin
                            disp_d[15:0] = wdata[15:0];
                        end
                    end else begin
                        disp_d = disp_q;
                    end
                end
                2'b10: begin
                    case (addr[1:0])
                        2'b00:   disp_d[7:0]   = wdata[7:0];
                        2'b01:   disp_d[15:8]  = wdata[7:0];
                        2'b10:   disp_d[23:16] = wdata[7:0];
                        2'b11:   disp_d[31:24] = wdata[7:0];
                        default: disp_d        = disp_q;
                    endcase
                end
                default: disp_d = disp_q;
            endcase
        end else begin
            disp_d = disp_q;
        end
    end

    // Free-running scan counter; its top three bits pick the digit slot.
    always_comb begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        idx_s = cnt_q[SCAN_DIV+2:SCAN_DIV];
    end

    // Nibble for the current digit slot.
    always_comb begin
        case (idx_s)
            3'd0:    nibble_s = disp_q[3:0];
            3'd1:    nibble_s = disp_q[7:4];
            3'd2:    nibble_s = disp_q[11:8];
            3'd3:    nibble_s = disp_q[15:12];
            3'd4:    nibble_s = disp_q[19:16];
            3'd5:    nibble_s = disp_q[23:20];
            3'd6:    nibble_s = disp_q[27:24];
            3'd7:    nibble_s = disp_q[31:28];
            default: nibble_s = 4'h0;
        endcase
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
    always_comb begin
        if ((idx_s != 3'd0) && ((disp_q >> {idx_s, 2'b00}) == 32'h0000_0000)) begin
            blank_s = 1'b1;
        end else begin
            blank_s = 1'b0;
        end
    end
`else
    // Every digit is always decoded.
    always_comb begin
        blank_s = 1'b0;
    end
`endif

    // Next output values; decimal point is permanently off.
    always_comb begin
        sel_d = ~(8'h01 << idx_s);
        if (blank_s) begin
            seg_d = 8'hFF;
        end else begin
            seg_d = {1'b1, hexdec(nibble_s)};
        end
    end

    // State and output registers; reset darkens the display immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            disp_q <= 32'h0000_0000;
            cnt_q  <= '0;
            seg_q  <= 8'hFF;
            sel_q  <= 8'hFF;
        end else begin
            disp_q <= disp_d;
            cnt_q  <= cnt_d;
            seg_q  <= seg_d;
            sel_q  <= sel_d;
        end
    end

endmodule

// File: tb/tb_seg7_mmio_display.sv
module tb_seg7_mmio_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [1:0]  wsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] rdata;
    logic [7:0]  o_seg;
    logic [7:0]  o_sel;

    int checks   = 0;
    int failures = 0;

    seg7_mmio_display #(
        .DISP_ADDR(32'h1001_FFF0),
        .SCAN_DIV (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .we   (we),
        .wsize(wsize),
        .addr (addr),
        .wdata(wdata),
        .hit  (hit),
        .rdata(rdata),
        .o_seg(o_seg),
        .o_sel(o_sel)
    );

    always #5 clk = ~clk;

    // Called at a negedge; the write is taken at the following posedge and
    // the task returns on the next negedge with the bus idle.
    task automatic cpu_write(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        we = 1'b1; wsize = sz; addr = a; wdata = d;
        @(negedge clk);
        we = 1'b0; wsize = 2'b00; addr = 32'h0; wdata = 32'h0;
    endtask

    // Returns at the first negedge of a digit-0 slot (o_sel went 7F -> FE).
    task automatic wait_digit0(output int n, output bit ok);
        logic [7:0] prev;
        prev = o_sel; ok = 1'b0; n = 0;
        for (int i = 0; i < 80 && !ok; i++) begin
            @(negedge clk);
            n++;
            if (o_sel == 8'hFE && prev == 8'h7F) ok = 1'b1;
            prev = o_sel;
        end
    endtask

    // Check all eight digit slots against an expected segment table.
    task automatic check_scan(input string name, input logic [7:0] exp_seg [8]);
        int n; bit ok;
        logic [7:0] one, exp_sel;
        wait_digit0(n, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s sync: digit0 slot not found, o_sel=%h", name, o_sel);
        end
        for (int i = 0; i < 8; i++) begin
            if (i > 0) repeat (4) @(negedge clk);
            one = 8'h01 << i;
            exp_sel = ~one;
            checks++;
            if (o_sel !== exp_sel || o_seg !== exp_seg[i]) begin
                failures++;
                $display("FAIL %s digit%0d: got sel=%h seg=%h expected sel=%h seg=%h",
                         name, i, o_sel, o_seg, exp_sel, exp_seg[i]);
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; we = 1'b0; wsize = 2'b00; addr = 32'h0; wdata = 32'h0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_seg !== 8'hFF || o_sel !== 8'hFF || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_hold: got seg=%h sel=%h rdata=%h expected FF FF 0", o_seg, o_sel, rdata);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_sel !== 8'hFE || o_seg !== 8'hC0) begin
            failures++;
            $display("FAIL reset_first_edge: got sel=%h seg=%h expected FE C0", o_sel, o_seg);
        end
        cpu_write(2'b00, 32'h1001_FFF0, 32'h8888_8888);
        repeat (5) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if (o_seg !== 8'hFF || o_sel !== 8'hFF || rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_midscan: got seg=%h sel=%h rdata=%h expected FF FF 0", o_seg, o_sel, rdata);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (o_sel !== 8'hFE || o_seg !== 8'hC0) begin
            failures++;
            $display("FAIL reset_rerelease: got sel=%h seg=%h expected FE C0", o_sel, o_seg);
        end
    endtask

    task automatic test_word_write;
        logic [7:0] exp [8];
        addr = 32'h1001_FFF0;
        #1;
        checks++;
        if (hit !== 1'b1) begin
            failures++;
            $display("FAIL hit_match: got %b expected 1", hit);
        end
        @(negedge clk);
        cpu_write(2'b00, 32'h1001_FFF0, 32'h1234_ABCD);
        checks++;
        if (rdata !== 32'h1234_ABCD) begin
            failures++;
            $display("FAIL word_write: got %h expected 1234abcd", rdata);
        end
        exp = '{8'hA1, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};
        check_scan("word_scan", exp);
    endtask

    task automatic test_partial_writes;
        cpu_write(2'b10, 32'h1001_FFF3, 32'h0000_005A);
        checks++;
        if (rdata !== 32'h5A34_ABCD) begin
            failures++;
            $display("FAIL byte_write: got %h expected 5a34abcd", rdata);
        end
        cpu_write(2'b01, 32'h1001_FFF0, 32'h0000_BEEF);
        checks++;
        if (rdata !== 32'h5A34_BEEF) begin
            failures++;
            $display("FAIL half_write_lo: got %h expected 5a34beef", rdata);
        end
        cpu_write(2'b01, 32'h1001_FFF2, 32'h0000_1357);
        checks++;
        if (rdata !== 32'h1357_BEEF) begin
            failures++;
            $display("FAIL half_write_hi: got %h expected 1357beef", rdata);
        end
        cpu_write(2'b10, 32'h1001_FFF1, 32'h0000_0042);
        checks++;
        if (rdata !== 32'h1357_42EF) begin
            failures++;
            $display("FAIL byte_write_lane1: got %h expected 135742ef", rdata);
        end
    endtask

    task automatic test_ignored;
        cpu_write(2'b01, 32'h1001_FFF1, 32'h0000_FFFF);
        checks++;
        if (rdata !== 32'h1357_42EF) begin
            failures++;
            $display("FAIL ign_half_misaligned: got %h expected 135742ef", rdata);
        end
        cpu_write(2'b11, 32'h1001_FFF0, 32'hFFFF_FFFF);
        checks++;
        if (rdata !== 32'h1357_42EF) begin
            failures++;
            $display("FAIL ign_reserved_size: got %h expected 135742ef", rdata);
        end
        cpu_write(2'b00, 32'h1001_FFF2, 32'hFFFF_FFFF);
        checks++;
        if (rdata !== 32'h1357_42EF) begin
            failures++;
            $display("FAIL ign_word_misaligned: got %h expected 135742ef", rdata);
        end
        addr = 32'h1001_0000;
        #1;
        checks++;
        if (hit !== 1'b0) begin
            failures++;
            $display("FAIL hit_miss: got %b expected 0", hit);
        end
        @(negedge clk);
        cpu_write(2'b00, 32'h1001_0000, 32'hFFFF_FFFF);
        checks++;
        if (rdata !== 32'h1357_42EF) begin
            failures++;
            $display("FAIL ign_no_hit: got %h expected 135742ef", rdata);
        end
    endtask

    task automatic test_wrap_latency;
        int n; bit ok;
        cpu_write(2'b00, 32'h1001_FFF0, 32'h0000_0000);
        wait_digit0(n, ok);
        wait_digit0(n, ok);
        checks++;
        if (!ok || n != 32) begin
            failures++;
            $display("FAIL wrap_period: got %0d cycles (found=%0d) expected 32", n, ok);
        end
        // Slot 1 starts at the posedge after negedge N+3; land the write on it.
        repeat (3) @(negedge clk);
        cpu_write(2'b00, 32'h1001_FFF0, 32'h0000_0050);
        checks++;
        if (o_sel !== 8'hFD || o_seg !== 8'hC0 || rdata !== 32'h0000_0050) begin
            failures++;
            $display("FAIL latency_same_edge: got sel=%h seg=%h rdata=%h expected FD C0 00000050",
                     o_sel, o_seg, rdata);
        end
        @(negedge clk);
        checks++;
        if (o_sel !== 8'hFD || o_seg !== 8'h92) begin
            failures++;
            $display("FAIL latency_next_edge: got sel=%h seg=%h expected FD 92", o_sel, o_seg);
        end
    endtask

    task automatic test_leading_zero;
        logic [7:0] exp [8];
        cpu_write(2'b00, 32'h1001_FFF0, 32'h0000_00F0);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp = '{8'hC0, 8'h8E, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
`else
        exp = '{8'hC0, 8'h8E, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
`endif
        check_scan("leading_zero", exp);
    endtask

    initial begin
        test_reset();
        test_word_write();
        test_partial_writes();
        test_ignored();
        test_wrap_latency();
        test_leading_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
